// File: rtl/exposure_sequencer_pkg.sv
// Shared state encodings, default timing constants and host command
// definitions for the exposure sequencer.
package exposure_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_FLUSH_TGL    = 4'd1,
    S_FLUSH_WAIT   = 4'd2,
    S_OPEN_SETTLE  = 4'd3,
    S_EXPOSE       = 4'd4,
    S_CLOSE_SETTLE = 4'd5,
    S_RD_TGL       = 4'd6,
    S_RD_WAIT      = 4'd7
  } state_e;

  localparam int TICK_DIV_DEF  = 100000;
  localparam int SETTLE_MS_DEF = 250;
  localparam int EXP_W_DEF     = 24;
  localparam int BUSY_TO_DEF   = 255;

  // Host expose command: 3-byte exp_ms operand plus a flag byte
  localparam logic [7:0] CMD_EXPOSE = 8'h45;
  localparam int FLAG_DARK  = 0;
  localparam int FLAG_FLUSH = 1;

  function automatic logic is_timed(state_e s);
    return (s == S_OPEN_SETTLE) ||
           (s == S_EXPOSE) ||
           (s == S_CLOSE_SETTLE);
  endfunction

  function automatic logic is_wait(state_e s);
    return (s == S_FLUSH_WAIT) ||
           (s == S_RD_WAIT);
  endfunction

endpackage

// File: rtl/exposure_sequencer_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV
// cycles while enabled; synchronous clear restarts the period.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         wrap;

  assign wrap = (cnt_q == W'(TICK_DIV - 1));
  assign tick = en & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/exposure_sequencer.sv
// Runs one CCD exposure: optional flush readout, shutter open/settle,
// timed integration, shutter close/settle, then the image readout.
module exposure_sequencer
  import exposure_sequencer_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int SETTLE_MS = SETTLE_MS_DEF,
  parameter int EXP_W     = EXP_W_DEF,
  parameter int BUSY_TO   = BUSY_TO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [EXP_W-1:0] exp_ms,
  input  logic             dark,
  input  logic             flush_en,
  input  logic             ccd_busy,
  output logic             shutter_open,
  output logic             ccd_toggle,
  output logic             discard,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [3:0]       state_out
);

  state_e state_q, state_d;

  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             dark_q, dark_d;
  logic             phase_q, phase_d;
  logic             abt_q, abt_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             err_q, err_d;

  logic tick;
  logic moved;
  logic cnt_zero;
  logic timer_done;
  logic abort_req;

  assign moved      = (state_d != state_q);
  assign cnt_zero   = (cnt_q == '0);
  assign timer_done = cnt_zero |
                      (tick & (cnt_q == EXP_W'(1)));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (moved),
    .en   (is_timed(state_q)),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_d = flush_en ? S_FLUSH_TGL :
                    dark     ? S_EXPOSE    :
                               S_OPEN_SETTLE;
      end
      S_FLUSH_TGL: begin
        if (abort)
          state_d = S_IDLE;
        else if (cnt_zero)
          state_d = S_FLUSH_WAIT;
      end
      S_FLUSH_WAIT: begin
        if (!phase_q) begin
          if (!ccd_busy && cnt_q == EXP_W'(1))
            state_d = S_IDLE;
        end else if (!ccd_busy) begin
          state_d = dark_q ? S_EXPOSE : S_OPEN_SETTLE;
        end
      end
      S_OPEN_SETTLE: begin
        if (abort)
          state_d = S_CLOSE_SETTLE;
        else if (timer_done)
          state_d = S_EXPOSE;
      end
      S_EXPOSE: begin
        if (abort)
          state_d = dark_q ? S_IDLE : S_CLOSE_SETTLE;
        else if (timer_done)
          state_d = dark_q ? S_RD_TGL : S_CLOSE_SETTLE;
      end
      S_CLOSE_SETTLE: begin
        if (timer_done)
          state_d = (abt_q | abort) ? S_IDLE : S_RD_TGL;
      end
      S_RD_TGL: begin
        if (cnt_zero)
          state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (!phase_q) begin
          if (!ccd_busy && cnt_q == EXP_W'(1))
            state_d = S_IDLE;
        end else if (!ccd_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shutter_open = (state_q == S_OPEN_SETTLE) ||
                   (state_q == S_EXPOSE && !dark_q);
    ccd_toggle   = (state_q == S_FLUSH_TGL) ||
                   (state_q == S_RD_TGL);
    discard      = (state_q == S_FLUSH_TGL) ||
                   (state_q == S_FLUSH_WAIT);
    busy         = (state_q != S_IDLE);
    state_out    = state_q;
  end

  assign done    = done_q;
  assign aborted = aborted_q;
  assign err     = err_q;

  // Aborts that must still pass through a closed-shutter settle
  assign abort_req = abort &&
                     ((state_q == S_OPEN_SETTLE) ||
                      (state_q == S_CLOSE_SETTLE) ||
                      (state_q == S_EXPOSE && !dark_q));

  always_comb begin
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    dark_d    = dark_q;
    phase_d   = phase_q;
    abt_d     = abt_q | abort_req;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = err_q;

    if (state_q == S_IDLE && start) begin
      exp_d  = exp_ms;
      dark_d = dark;
      err_d  = 1'b0;
      abt_d  = 1'b0;
    end

    if (is_wait(state_q) && !phase_q && ccd_busy)
      phase_d = 1'b1;

    if (moved) begin
      phase_d = 1'b0;
      unique case (state_d)
        S_FLUSH_TGL,
        S_RD_TGL:       cnt_d = EXP_W'(1);
        S_FLUSH_WAIT,
        S_RD_WAIT:      cnt_d = EXP_W'(BUSY_TO);
        S_OPEN_SETTLE,
        S_CLOSE_SETTLE: cnt_d = EXP_W'(SETTLE_MS);
        S_EXPOSE:       cnt_d = (state_q == S_IDLE) ?
                                exp_ms : exp_q;
        default:        cnt_d = '0;
      endcase
      if (state_d == S_IDLE) begin
        if (is_wait(state_q)) begin
          done_d = phase_q;
          err_d  = ~phase_q;
        end else begin
          aborted_d = 1'b1;
        end
      end
    end else if (!cnt_zero &&
                 (ccd_toggle ||
                  (is_wait(state_q) && !phase_q) ||
                  (is_timed(state_q) && tick))) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      exp_q     <= '0;
      dark_q    <= 1'b0;
      phase_q   <= 1'b0;
      abt_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      dark_q    <= dark_d;
      phase_q   <= phase_d;
      abt_q     <= abt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Scoreboard bench: stimulus queues expected output events with their
// cycle stamps, a negedge monitor pops and compares each observed edge.
module tb_exposure_sequencer;

  localparam int TD = 10;
  localparam int SM = 2;
  localparam int EW = 24;
  localparam int BT = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [EW-1:0] exp_ms;
  logic          dark;
  logic          flush_en;
  logic          ccd_busy;
  logic          shutter_open;
  logic          ccd_toggle;
  logic          discard;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          err;
  logic [3:0]    state_out;

  exposure_sequencer #(
    .TICK_DIV  (TD),
    .SETTLE_MS (SM),
    .EXP_W     (EW),
    .BUSY_TO   (BT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .exp_ms       (exp_ms),
    .dark         (dark),
    .flush_en     (flush_en),
    .ccd_busy     (ccd_busy),
    .shutter_open (shutter_open),
    .ccd_toggle   (ccd_toggle),
    .discard      (discard),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .err          (err),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {
    EV_SH_R, EV_SH_F, EV_TG_R, EV_TG_F, EV_DS_R,
    EV_DS_F, EV_DONE, EV_ABT, EV_ER_R, EV_ER_F
  } ev_e;

  typedef struct {
    ev_e k;
    int  c;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  fails  = 0;
  logic mon_en = 1'b0;
  logic bm_en  = 1'b0;

  task automatic exp_ev(ev_e k, int c);
    ev_t e;
    e.k = k;
    e.c = c;
    expq.push_back(e);
  endtask

  task automatic see(ev_e k);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL event %s at cycle %0d, expected none",
               k.name(), cyc);
    end else begin
      e = expq.pop_front();
      if (e.k != k || e.c != cyc) begin
        fails++;
        $display("FAIL event got %s @%0d, required %s @%0d",
                 k.name(), cyc, e.k.name(), e.c);
      end
    end
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", n, act, req);
    end
  endtask

  logic p_sh = 0, p_tg = 0, p_ds = 0, p_er = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (shutter_open && !p_sh) see(EV_SH_R);
      if (!shutter_open && p_sh) see(EV_SH_F);
      if (ccd_toggle && !p_tg)   see(EV_TG_R);
      if (!ccd_toggle && p_tg)   see(EV_TG_F);
      if (discard && !p_ds)      see(EV_DS_R);
      if (!discard && p_ds)      see(EV_DS_F);
      if (done)                  see(EV_DONE);
      if (aborted)               see(EV_ABT);
      if (err && !p_er)          see(EV_ER_R);
      if (!err && p_er)          see(EV_ER_F);
    end
    p_sh <= shutter_open;
    p_tg <= ccd_toggle;
    p_ds <= discard;
    p_er <= err;
  end

  // ccd_readout model: busy rises 3 cycles after the toggle ends,
  // stays high for 20 cycles
  int   bd = 0, bh = 0;
  logic tg_prev = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (bd > 0) begin
      bd--;
      if (bd == 0) begin
        ccd_busy = 1'b1;
        bh = 20;
      end
    end else if (bh > 0) begin
      bh--;
      if (bh == 0) ccd_busy = 1'b0;
    end
    if (bm_en && tg_prev && !ccd_toggle) bd = 3;
    tg_prev = ccd_toggle;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(int t);
    while (cyc < t) step();
  endtask

  task automatic do_start(int e, logic d, logic f, logic ab,
                          output int s);
    exp_ms   = EW'(e);
    dark     = d;
    flush_en = f;
    abort    = ab;
    start    = 1'b1;
    s        = cyc;
    step();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy) begin
      fails++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, required 0",
               budget);
    end
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, x;
    rst = 1'b1; start = 0; abort = 0; exp_ms = '0;
    dark = 0; flush_en = 0; ccd_busy = 0;
    repeat (3) step();
    chk("rst shutter_open", 32'(shutter_open), 0);
    chk("rst ccd_toggle", 32'(ccd_toggle), 0);
    chk("rst discard", 32'(discard), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst aborted", 32'(aborted), 0);
    chk("rst err", 32'(err), 0);
    chk("rst state_out", 32'(state_out), 0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;
    bm_en  = 1'b1;
    step();

    // plain exposure, with an ignored start mid-exposure
    do_start(5, 0, 0, 0, s);
    exp_ev(EV_SH_R, s + 1);
    exp_ev(EV_SH_F, s + 71);
    exp_ev(EV_TG_R, s + 91);
    exp_ev(EV_TG_F, s + 93);
    exp_ev(EV_DONE, s + 117);
    go_to(s + 50);
    do_start(3, 1, 1, 0, x);
    wait_idle(400);
    chk("sc1 err", 32'(err), 0);

    // flush readout first
    do_start(5, 0, 1, 0, s);
    exp_ev(EV_TG_R, s + 1);
    exp_ev(EV_DS_R, s + 1);
    exp_ev(EV_TG_F, s + 3);
    exp_ev(EV_SH_R, s + 27);
    exp_ev(EV_DS_F, s + 27);
    exp_ev(EV_SH_F, s + 97);
    exp_ev(EV_TG_R, s + 117);
    exp_ev(EV_TG_F, s + 119);
    exp_ev(EV_DONE, s + 143);
    wait_idle(400);

    // readout never goes busy, dark with exp_ms=0
    bm_en = 1'b0;
    do_start(0, 1, 0, 0, s);
    exp_ev(EV_TG_R, s + 2);
    exp_ev(EV_TG_F, s + 4);
    exp_ev(EV_ER_R, s + 259);
    wait_idle(400);
    chk("sc5 err sticky", 32'(err), 1);
    bm_en = 1'b1;

    // dark frame; start and abort together, start wins
    do_start(3, 1, 0, 1, s);
    exp_ev(EV_ER_F, s + 1);
    exp_ev(EV_TG_R, s + 31);
    exp_ev(EV_TG_F, s + 33);
    exp_ev(EV_DONE, s + 57);
    wait_idle(400);
    chk("sc3 err", 32'(err), 0);

    // abort during shutter-open exposure
    do_start(5, 0, 0, 0, s);
    exp_ev(EV_SH_R, s + 1);
    go_to(s + 36);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_ev(EV_SH_F, s + 37);
    exp_ev(EV_ABT, s + 57);
    wait_idle(400);

    // abort during dark exposure
    do_start(5, 1, 0, 0, s);
    go_to(s + 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_ev(EV_ABT, s + 11);
    wait_idle(400);

    // reset mid-exposure
    do_start(5, 0, 0, 0, s);
    exp_ev(EV_SH_R, s + 1);
    go_to(s + 30);
    rst = 1'b1;
    exp_ev(EV_SH_F, s + 30);
    #1;
    chk("mid-rst shutter_open", 32'(shutter_open), 0);
    chk("mid-rst state_out", 32'(state_out), 0);
    chk("mid-rst busy", 32'(busy), 0);
    step();
    rst = 1'b0;
    repeat (5) step();

    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL pending events: %0d left, required 0",
               expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/exposure_sequencer.md
# exposure_sequencer

Sequences one CCD exposure end to end: optional flush readout, shutter open, timed integration, shutter close, then the image readout. It sits in `top` between the command state machine and the `ccd_readout` block. It drives the shutter-state bit that selects the shutter PWM duty cycle, and it drives the `ccd_readout` toggle. The host issues a single start command and gets back a done or aborted indication, instead of hand-timing the shutter and readout over USB.

## Interface
- `TICK_DIV`, 100000: `clk` cycles per exposure tick (1 ms at 100 MHz).
- `SETTLE_MS`, 250: shutter servo settle time in ticks, applied after every open and every close command.
- `EXP_W`, 24: width of the exposure-time operand.
- `BUSY_TO`, 255: maximum cycles allowed from the end of the toggle until `ccd_busy` rises.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset; asynchronous, active-high.
- `start` in 1: single-cycle request; ignored unless `busy`=0.
- `abort` in 1: single-cycle abort request.
- `exp_ms` in EXP_W: exposure length in ticks; sampled on the accepted `start`.
- `dark` in 1: dark frame (shutter stays closed); sampled on `start`.
- `flush_en` in 1: perform a discard readout before exposing; sampled on `start`.
- `ccd_busy` in 1: busy output of `ccd_readout`.
- `shutter_open` out 1: 1 = open duty cycle, 0 = closed.
- `ccd_toggle` out 1: readout trigger.
- `discard` out 1: high for the whole flush readout, so the tx path drops the pixel data.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse when the image readout completes.
- `aborted` out 1: one-cycle pulse when a sequence ends by abort.
- `err` out 1: sticky readout-timeout flag; cleared by the next accepted `start`.
- `state_out` out 4: current state encoding, for status and debug.

## Operation
- States: IDLE, FLUSH_TGL, FLUSH_WAIT, OPEN_SETTLE, EXPOSE, CLOSE_SETTLE, RD_TGL, RD_WAIT.
- IDLE: an accepted `start` latches `exp_ms`, `dark` and `flush_en`, clears `err`, and moves to the first active state:
  - FLUSH_TGL if `flush_en`=1;
  - otherwise OPEN_SETTLE, or EXPOSE when `dark`=1.
- FLUSH_TGL / RD_TGL: assert `ccd_toggle` for exactly 2 cycles, then go to the matching WAIT state.
- FLUSH_WAIT / RD_WAIT each run two phases:
  - Phase 1: wait for `ccd_busy`=1. If it has not risen within `BUSY_TO` cycles, set `err` and go to IDLE with no `done`.
  - Phase 2: wait for `ccd_busy`=0.
  - On completion, FLUSH_WAIT goes to OPEN_SETTLE, or to EXPOSE when dark. RD_WAIT pulses `done` and goes to IDLE.
- OPEN_SETTLE: `shutter_open`=1 and wait `SETTLE_MS` ticks, then EXPOSE.
- EXPOSE: count the latched `exp_ms` ticks.
  - `shutter_open` stays 1, or 0 when dark.
  - `exp_ms`=0 leaves after 1 cycle.
  - On exit: go to CLOSE_SETTLE when not dark; when dark, go straight to RD_TGL.
- CLOSE_SETTLE: `shutter_open`=0 and wait `SETTLE_MS` ticks, then RD_TGL.
- `abort`:
  - In OPEN_SETTLE or EXPOSE (not dark): go to CLOSE_SETTLE, then IDLE with an `aborted` pulse and no readout.
  - In EXPOSE (dark) or FLUSH_TGL: go to IDLE next cycle with an `aborted` pulse.
  - In CLOSE_SETTLE: the readout is skipped.
  - In the WAIT states and RD_TGL: ignored, because a readout in progress cannot be stopped.
- Simultaneous `start`+`abort` in IDLE: `start` wins and `abort` is ignored.
- `discard`=1 exactly in FLUSH_TGL and FLUSH_WAIT.

## Timing
- Reset values: state IDLE; all outputs 0 (`shutter_open`=0, i.e. closed); all counters cleared.
- Tick prescaler: reset to 0 on every entry to OPEN_SETTLE, EXPOSE and CLOSE_SETTLE, so each timed state lasts exactly N×`TICK_DIV` cycles, ±0.
- Accepted `start` to the first `ccd_toggle` (flush) or to `shutter_open` rising: 1 cycle.
- Non-dark, no flush, no abort: `start` to the first RD_TGL cycle = 1 + (2×`SETTLE_MS` + `exp_ms`)×`TICK_DIV` cycles.
- `done` asserts the cycle after `ccd_busy` is sampled low in RD_WAIT.
- The tick counter is ceil(log2(`TICK_DIV`)) bits. The exposure counter is `EXP_W` bits and counts down to 0, so there is no wrap.
- `rst` asserted mid-sequence: the shutter goes closed and `ccd_toggle` drops asynchronously. Any readout already running in `ccd_readout` is not cancelled.

## Structure
- Shared header `exposure_sequencer.vh` holds the state localparams (4-bit, shared with the host status decoder) and the default tick and settle constants.
- Sub-module `tick_prescaler`: synchronous clear input, enable input, one-cycle `tick` output every `TICK_DIV` cycles. Used by all timed states.
- Also in the header: the host command byte `cmd_expose`, which `top` decodes. Its 3-byte operand loads `exp_ms` and its flag byte drives `dark` and `flush_en`.

## Test plan
All scenarios run with `TICK_DIV`=10 and `SETTLE_MS`=2, and with the bench modelling `ccd_busy` as high 3 cycles after the toggle ends, for 20 cycles. Scenarios 4–6 rely on the same settings.
1. `start`, `exp_ms`=5, not dark, no flush:
   - `shutter_open` high for exactly 70 cycles;
   - `ccd_toggle` 2 cycles, starting 91 cycles after `start`;
   - `done` one cycle after `ccd_busy` falls; `err`=0.
2. Same as scenario 1 with `flush_en`=1:
   - `discard` high through the first readout;
   - shutter opens the cycle after flush `ccd_busy` falls;
   - 2 toggles total, 1 `done`.
3. `dark`=1, `exp_ms`=3: `shutter_open` never rises; RD_TGL 31 cycles after `start`; `done` pulses.
4. `abort` 15 cycles into EXPOSE:
   - shutter closes next cycle, 20-cycle settle, then IDLE with an `aborted` pulse;
   - no `ccd_toggle`, no `done`.
5. `ccd_busy` held 0:
   - `err`=1 exactly `BUSY_TO` cycles after the toggle ends, then IDLE with no `done`;
   - the next `start` clears `err`.
6. Edge cases:
   - `start` pulsed while `busy` is ignored;
   - `exp_ms`=0 gives a 1-cycle EXPOSE;
   - `rst` during EXPOSE gives `shutter_open`=0 and IDLE immediately.
